// File: rtl/ex_mem_pipe_pkg.sv
`default_nettype none
// ============================================================================
// Module : ex_mem_pipe_pkg
// Purpose: Shared defaults and halt-FSM state encoding for the EX/MEM stage.
// Ports  : none (package)
// Rev    : 1.0  initial release
// ============================================================================
package ex_mem_pipe_pkg;

  localparam int DATA_W_DEF = 16;
  localparam int REG_W_DEF  = 3;
  localparam int CNT_W_DEF  = 16;

  // Halt sequencing states
  localparam logic [1:0] ST_RUN        = 2'd0;
  localparam logic [1:0] ST_HALT_PULSE = 2'd1;
  localparam logic [1:0] ST_HALTED     = 2'd2;

endpackage
`default_nettype wire

// File: rtl/ex_mem_pipe_if.sv
`default_nettype none
// ============================================================================
// Module : ex_mem_pipe_if
// Purpose: Bundles the EX-side inputs, stage controls and MEM-side outputs
//          of the EX/MEM pipeline register.
// Ports  : master - the pipeline stage (consumes ex_*/stall/flush, drives
//                   valid/aluRes/writedata/memWrite/MemRead/... /stall_cnt)
//          slave  - the surrounding pipeline (drives ex_*, observes outputs)
// Rev    : 1.0  initial release
// ============================================================================
interface ex_mem_pipe_if
  import ex_mem_pipe_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF,
  parameter int REG_W  = REG_W_DEF,
  parameter int CNT_W  = CNT_W_DEF
);

  // EX side
  logic              ex_valid;
  logic [DATA_W-1:0] ex_aluRes;
  logic [DATA_W-1:0] ex_writeData;
  logic              ex_memWrite;
  logic              ex_memRead;
  logic              ex_regWrite;
  logic              ex_memToReg;
  logic [REG_W-1:0]  ex_writeReg;
  logic              ex_halt;
  logic              stall;
  logic              flush;

  // MEM side
  logic              valid;
  logic [DATA_W-1:0] aluRes;
  logic [DATA_W-1:0] writedata;
  logic              memWrite;
  logic              MemRead;
  logic              regWrite;
  logic              memToReg;
  logic [REG_W-1:0]  writeReg;
  logic              halt;
  logic              misalign;
  logic              fwd_en;
  logic [CNT_W-1:0]  stall_cnt;

  modport master (
    input  ex_valid, ex_aluRes, ex_writeData, ex_memWrite, ex_memRead,
           ex_regWrite, ex_memToReg, ex_writeReg, ex_halt, stall, flush,
    output valid, aluRes, writedata, memWrite, MemRead, regWrite, memToReg,
           writeReg, halt, misalign, fwd_en, stall_cnt
  );

  modport slave (
    output ex_valid, ex_aluRes, ex_writeData, ex_memWrite, ex_memRead,
           ex_regWrite, ex_memToReg, ex_writeReg, ex_halt, stall, flush,
    input  valid, aluRes, writedata, memWrite, MemRead, regWrite, memToReg,
           writeReg, halt, misalign, fwd_en, stall_cnt
  );

endinterface
`default_nettype wire

// File: rtl/ex_mem_pipe_sat_counter.sv
`default_nettype none
// ============================================================================
// Module : sat_counter
// Purpose: Up-counter that sticks at all-ones; async active-low clear.
// Ports  : clk   - clock, rising edge
//          rst_n - asynchronous clear, active-low
//          en    - count enable
//          count - current value
// Rev    : 1.0  initial release
// ============================================================================
module sat_counter #(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en,
  output logic [WIDTH-1:0] count
);

  localparam logic [WIDTH-1:0] ALL_ONES = {WIDTH{1'b1}};
  localparam logic [WIDTH-1:0] ONE      = {{(WIDTH-1){1'b0}}, 1'b1};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count <= '0;
    end else if (en && (count != ALL_ONES)) begin
      count <= count + ONE;
    end
  end

endmodule
`default_nettype wire

// File: rtl/ex_mem_pipe.sv
`default_nettype none
// ============================================================================
// Module : ex_mem_pipe
// Purpose: EX/MEM pipeline register with valid gating, stall/flush control,
//          misaligned-access blocking, forwarding enable and halt sequencing.
// Ports  : clk   - clock, rising edge
//          rst_n - asynchronous reset, active-low
//          bus   - ex_mem_pipe_if.master (EX inputs, stall/flush, MEM outputs,
//                  stall_cnt)
// Rev    : 1.0  initial release
// ============================================================================
module ex_mem_pipe
  import ex_mem_pipe_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF,
  parameter int REG_W  = REG_W_DEF,
  parameter int CNT_W  = CNT_W_DEF
) (
  input  logic          clk,
  input  logic          rst_n,
  ex_mem_pipe_if.master bus
);

  logic              valid_q;
  logic [DATA_W-1:0] alu_q;
  logic [DATA_W-1:0] wdata_q;
  logic              mem_wr_q;
  logic              mem_rd_q;
  logic              reg_wr_q;
  logic              mem_to_reg_q;
  logic [REG_W-1:0]  wreg_q;
  logic [1:0]        state;
  logic [1:0]        state_nxt;
  logic              load_bubble;
  logic              halt_taken;
  logic              mis;

  // Once a halt has been taken, nothing new may enter the stage.
  assign load_bubble = bus.flush || (state != ST_RUN);
  assign halt_taken  = !bus.stall && !load_bubble && bus.ex_valid && bus.ex_halt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_q      <= 1'b0;
      alu_q        <= '0;
      wdata_q      <= '0;
      mem_wr_q     <= 1'b0;
      mem_rd_q     <= 1'b0;
      reg_wr_q     <= 1'b0;
      mem_to_reg_q <= 1'b0;
      wreg_q       <= '0;
    end else if (!bus.stall) begin
      if (load_bubble) begin
        valid_q      <= 1'b0;
        alu_q        <= '0;
        wdata_q      <= '0;
        mem_wr_q     <= 1'b0;
        mem_rd_q     <= 1'b0;
        reg_wr_q     <= 1'b0;
        mem_to_reg_q <= 1'b0;
        wreg_q       <= '0;
      end else begin
        valid_q      <= bus.ex_valid;
        alu_q        <= bus.ex_aluRes;
        wdata_q      <= bus.ex_writeData;
        // A halt instruction is architecturally side-effect free.
        mem_wr_q     <= bus.ex_memWrite & ~bus.ex_halt;
        mem_rd_q     <= bus.ex_memRead  & ~bus.ex_halt;
        reg_wr_q     <= bus.ex_regWrite & ~bus.ex_halt;
        mem_to_reg_q <= bus.ex_memToReg;
        wreg_q       <= bus.ex_writeReg;
      end
    end
  end

  // Halt FSM: the pulse state stretches while stalled so the dump request
  // is seen by a memory stage that is itself held.
  always_comb begin
    state_nxt = state;
    case (state)
      ST_RUN:        if (halt_taken) state_nxt = ST_HALT_PULSE;
      ST_HALT_PULSE: if (!bus.stall) state_nxt = ST_HALTED;
      ST_HALTED:     state_nxt = ST_HALTED;
      default:       state_nxt = ST_RUN;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= ST_RUN;
    end else begin
      state <= state_nxt;
    end
  end

  sat_counter #(.WIDTH(CNT_W)) u_stall_cnt (
    .clk   (clk),
    .rst_n (rst_n),
    .en    (bus.stall),
    .count (bus.stall_cnt)
  );

  // Odd address on a real memory op: suppress the access; the trap is
  // handled elsewhere, so regWrite still flows through.
  assign mis = valid_q & (mem_rd_q | mem_wr_q) & alu_q[0];

  assign bus.valid     = valid_q;
  assign bus.aluRes    = alu_q;
  assign bus.writedata = wdata_q;
  assign bus.memWrite  = valid_q & mem_wr_q & ~mis;
  assign bus.MemRead   = valid_q & mem_rd_q & ~mis;
  assign bus.regWrite  = valid_q & reg_wr_q;
  assign bus.memToReg  = mem_to_reg_q;
  assign bus.writeReg  = wreg_q;
  assign bus.halt      = (state == ST_HALT_PULSE);
  assign bus.misalign  = mis;
  assign bus.fwd_en    = valid_q & reg_wr_q & ~mem_to_reg_q;

endmodule
`default_nettype wire

// File: tb/tb_ex_mem_pipe.sv
`default_nettype none
// ============================================================================
// Module : tb_ex_mem_pipe
// Purpose: Self-checking bench for ex_mem_pipe: directed vector table,
//          hand-written halt / async-reset / saturation sequences, and
//          randomized stimulus against a behavioural model.
// Rev    : 1.0  initial release
// ============================================================================
module tb_ex_mem_pipe;

  localparam int DW = 16;
  localparam int RW = 3;
  localparam int CW = 16;
  localparam int CNT_MAX = (1 << CW) - 1;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  ex_mem_pipe_if #(.DATA_W(DW), .REG_W(RW), .CNT_W(CW)) bus ();

  ex_mem_pipe #(.DATA_W(DW), .REG_W(RW), .CNT_W(CW)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  int n_pass  = 0;
  int n_total = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  // Packed view: {valid,memWrite,MemRead,regWrite,memToReg,halt,misalign,fwd_en,writeReg,aluRes,writedata}
  function automatic logic [63:0] pk(logic v, logic mw, logic mr, logic rw, logic m2r,
                                     logic h, logic mis, logic fwd, logic [2:0] wr,
                                     logic [15:0] alu, logic [15:0] wd);
    return {21'd0, v, mw, mr, rw, m2r, h, mis, fwd, wr, alu, wd};
  endfunction

  function automatic logic [63:0] dut_out();
    return pk(bus.valid, bus.memWrite, bus.MemRead, bus.regWrite, bus.memToReg,
              bus.halt, bus.misalign, bus.fwd_en, bus.writeReg, bus.aluRes, bus.writedata);
  endfunction

  task automatic drive(input logic v, input logic mw, input logic mr, input logic rw,
                       input logic m2r, input logic [2:0] wr, input logic [15:0] alu,
                       input logic [15:0] wd, input logic h, input logic st, input logic fl);
    bus.ex_valid     = v;
    bus.ex_memWrite  = mw;
    bus.ex_memRead   = mr;
    bus.ex_regWrite  = rw;
    bus.ex_memToReg  = m2r;
    bus.ex_writeReg  = wr;
    bus.ex_aluRes    = alu;
    bus.ex_writeData = wd;
    bus.ex_halt      = h;
    bus.stall        = st;
    bus.flush        = fl;
  endtask

  // ---------------- behavioural reference model ----------------
  // The stage is "an instruction slot" plus a halt lifecycle:
  // running -> pulsing (dump request) -> halted (dead until reset).
  bit          m_v, m_mw, m_mr, m_rw, m_m2r;
  logic [2:0]  m_wr;
  logic [15:0] m_alu, m_wd;
  bit          m_pulsing, m_halted;
  int          m_cnt;

  task automatic m_reset();
    m_v = 0; m_mw = 0; m_mr = 0; m_rw = 0; m_m2r = 0;
    m_wr = '0; m_alu = '0; m_wd = '0;
    m_pulsing = 0; m_halted = 0; m_cnt = 0;
  endtask

  task automatic m_clock();
    bit accept;
    if (bus.stall) begin
      m_cnt = (m_cnt < CNT_MAX) ? m_cnt + 1 : CNT_MAX;
    end else begin
      accept = !bus.flush && !m_pulsing && !m_halted;
      if (accept) begin
        m_v   = bus.ex_valid;
        m_alu = bus.ex_aluRes;
        m_wd  = bus.ex_writeData;
        m_mw  = bus.ex_memWrite && !bus.ex_halt;
        m_mr  = bus.ex_memRead  && !bus.ex_halt;
        m_rw  = bus.ex_regWrite && !bus.ex_halt;
        m_m2r = bus.ex_memToReg;
        m_wr  = bus.ex_writeReg;
      end else begin
        m_v = 0; m_mw = 0; m_mr = 0; m_rw = 0; m_m2r = 0;
        m_wr = '0; m_alu = '0; m_wd = '0;
      end
      if (m_pulsing) begin
        m_pulsing = 0;
        m_halted  = 1;
      end else if (accept && bus.ex_valid && bus.ex_halt) begin
        m_pulsing = 1;
      end
    end
  endtask

  function automatic logic [63:0] m_expect();
    bit odd_mem;
    odd_mem = m_v && (m_mr || m_mw) && m_alu[0];
    return pk(m_v, m_v && m_mw && !odd_mem, m_v && m_mr && !odd_mem, m_v && m_rw,
              m_m2r, m_pulsing, odd_mem, m_v && m_rw && !m_m2r, m_wr, m_alu, m_wd);
  endfunction

  // Advance one clock; outputs are sampled 1 time unit after the edge.
  task automatic step();
    m_clock();
    @(posedge clk);
    #1;
  endtask

  // Short async reset pulse, well away from any clock edge.
  task automatic arst();
    rst_n = 1'b0;
    #2;
    rst_n = 1'b1;
    m_reset();
  endtask

  // ---------------- directed vector table ----------------
  typedef struct {
    logic        v, mw, mr, rw, m2r;
    logic [2:0]  wr;
    logic [15:0] alu, wd;
    logic        h, st, fl;
    logic [63:0] exp;
  } vec_t;

  vec_t tv[10];

  initial begin
    #1_500_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    logic [63:0] held;
    m_reset();
    drive(0, 0, 0, 0, 0, 3'd0, 16'h0, 16'h0, 0, 0, 0);

    // store
    tv[0] = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 3'd0, 16'h0040, 16'hBEEF, 1'b0, 1'b0, 1'b0,
              pk(1, 1, 0, 0, 0, 0, 0, 0, 3'd0, 16'h0040, 16'hBEEF)};
    // load to 0x0010
    tv[1] = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 3'd5, 16'h0010, 16'h1111, 1'b0, 1'b0, 1'b0,
              pk(1, 0, 1, 1, 1, 0, 0, 0, 3'd5, 16'h0010, 16'h1111)};
    held = pk(1, 0, 1, 1, 1, 0, 0, 0, 3'd5, 16'h0010, 16'h1111);
    // stall with changing EX inputs, then stall+flush: all held
    tv[2] = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 3'd2, 16'h0ABC, 16'h2222, 1'b0, 1'b1, 1'b0, held};
    tv[3] = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 3'd6, 16'h0F00, 16'h3333, 1'b0, 1'b1, 1'b0, held};
    tv[4] = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 3'd1, 16'h0200, 16'h4444, 1'b0, 1'b1, 1'b1, held};
    // flush of a valid load -> bubble
    tv[5] = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 3'd2, 16'h0030, 16'h5555, 1'b0, 1'b0, 1'b1,
              pk(0, 0, 0, 0, 0, 0, 0, 0, 3'd0, 16'h0000, 16'h0000)};
    // misaligned load: MemRead blocked, regWrite passes
    tv[6] = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 3'd3, 16'h0021, 16'h0000, 1'b0, 1'b0, 1'b0,
              pk(1, 0, 0, 1, 1, 0, 1, 0, 3'd3, 16'h0021, 16'h0000)};
    // ALU op: forwardable
    tv[7] = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 3'd7, 16'h1234, 16'h5678, 1'b0, 1'b0, 1'b0,
              pk(1, 0, 0, 1, 0, 0, 0, 1, 3'd7, 16'h1234, 16'h5678)};
    // invalid slot: controls gated, data still registered, no misalign
    tv[8] = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 3'd4, 16'h0041, 16'hAAAA, 1'b0, 1'b0, 1'b0,
              pk(0, 0, 0, 0, 1, 0, 0, 0, 3'd4, 16'h0041, 16'hAAAA)};
    // misaligned store
    tv[9] = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 3'd0, 16'h0003, 16'h0F0F, 1'b0, 1'b0, 1'b0,
              pk(1, 0, 0, 0, 0, 0, 1, 0, 3'd0, 16'h0003, 16'h0F0F)};

    // ---- reset state ----
    repeat (2) @(posedge clk);
    #1;
    chk("reset_outputs", dut_out(), 64'd0);
    chk("reset_stall_cnt", 64'(bus.stall_cnt), 64'd0);
    rst_n = 1'b1;

    // ---- table ----
    for (int i = 0; i < 10; i++) begin
      drive(tv[i].v, tv[i].mw, tv[i].mr, tv[i].rw, tv[i].m2r, tv[i].wr,
            tv[i].alu, tv[i].wd, tv[i].h, tv[i].st, tv[i].fl);
      @(posedge clk);
      #1;
      chk($sformatf("vec%0d", i), dut_out(), tv[i].exp);
    end
    chk("table_stall_cnt", 64'(bus.stall_cnt), 64'd3);

    // ---- halt with stall stretching the pulse ----
    drive(0, 0, 0, 0, 0, 3'd0, 16'h0, 16'h0, 0, 0, 0);
    arst();
    drive(1, 1, 0, 1, 0, 3'd2, 16'h0050, 16'h0000, 1, 0, 0);
    step();
    chk("halt_load", dut_out(), pk(1, 0, 0, 0, 0, 1, 0, 0, 3'd2, 16'h0050, 16'h0000));
    bus.stall = 1'b1;
    step();
    chk("halt_stall1", 64'(bus.halt), 64'd1);
    step();
    chk("halt_stall2", 64'(bus.halt), 64'd1);
    drive(1, 1, 0, 0, 0, 3'd0, 16'h0060, 16'h0001, 0, 0, 0);
    step();
    chk("halt_drop", dut_out(), 64'd0);
    for (int i = 0; i < 3; i++) begin
      step();
      chk($sformatf("halted_store%0d", i), {62'd0, bus.valid, bus.memWrite}, 64'd0);
    end
    arst();
    step();
    chk("post_reset_store", dut_out(), pk(1, 1, 0, 0, 0, 0, 0, 0, 3'd0, 16'h0060, 16'h0001));

    // ---- async reset mid-cycle, no clock edge ----
    bus.stall = 1'b1;
    step();
    chk("pre_arst_cnt", 64'(bus.stall_cnt), 64'd1);
    chk("pre_arst_memWrite", 64'(bus.memWrite), 64'd1);
    #2;
    rst_n = 1'b0;
    #1;
    chk("arst_memWrite", 64'(bus.memWrite), 64'd0);
    chk("arst_valid", 64'(bus.valid), 64'd0);
    chk("arst_stall_cnt", 64'(bus.stall_cnt), 64'd0);
    rst_n = 1'b1;
    m_reset();

    // ---- randomized against model ----
    drive(0, 0, 0, 0, 0, 3'd0, 16'h0, 16'h0, 0, 0, 0);
    @(posedge clk);
    #1;
    arst();
    for (int i = 0; i < 600; i++) begin
      if ((i % 150) == 149) arst();
      drive(1'($urandom_range(0, 3) != 0), 1'($urandom), 1'($urandom), 1'($urandom),
            1'($urandom), 3'($urandom), 16'($urandom), 16'($urandom),
            1'($urandom_range(0, 39) == 0), 1'($urandom_range(0, 3) == 0),
            1'($urandom_range(0, 7) == 0));
      step();
      chk("rand_out", dut_out(), m_expect());
      chk("rand_cnt", 64'(bus.stall_cnt), 64'(m_cnt));
    end

    // ---- stall counter saturation ----
    drive(0, 0, 0, 0, 0, 3'd0, 16'h0, 16'h0, 0, 1, 0);
    arst();
    repeat (CNT_MAX - 1) @(posedge clk);
    #1;
    chk("sat_below", 64'(bus.stall_cnt), 64'(CNT_MAX - 1));
    repeat (6) @(posedge clk);
    #1;
    chk("sat_full", 64'(bus.stall_cnt), 64'(CNT_MAX));

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/ex_mem_pipe.md
Name: ex_mem_pipe

Overview:
- EX/MEM pipeline register and control stage. Sits directly upstream of the data-memory stage.
- Captures EX results, gates memory control with a valid bit, and supports stall, flush and halt sequencing.
- Blocks misaligned accesses and provides MEM-stage forwarding data back to EX.
- Outputs drive the data-memory stage (memWrite, MemRead, aluRes, writedata, halt) and the MEM/WB register.

Parameters:
- DATA_W, 16, datapath width
- REG_W, 3, register-specifier width
- CNT_W, 16, stall performance-counter width

Ports:
- clk  in  1  clock, rising edge
- rst  in  1  reset, asynchronous, active-low
- ex_valid  in  1  EX holds a real instruction
- ex_aluRes  in  DATA_W  ALU result / memory address
- ex_writeData  in  DATA_W  store data
- ex_memWrite  in  1  store
- ex_memRead  in  1  load
- ex_regWrite  in  1  instruction writes RF
- ex_memToReg  in  1  WB source is memory
- ex_writeReg  in  REG_W  destination register
- ex_halt  in  1  HALT instruction
- stall  in  1  hold stage contents
- flush  in  1  replace incoming instruction with bubble
- valid  out  1  stage holds real instruction
- aluRes  out  DATA_W  registered address/result
- writedata  out  DATA_W  registered store data
- memWrite  out  1  valid & store & ~misalign
- MemRead  out  1  valid & load & ~misalign
- regWrite  out  1  valid & regWrite
- memToReg  out  1  registered
- writeReg  out  REG_W  registered
- halt  out  1  one-cycle halt/dump pulse
- misalign  out  1  valid memory op with aluRes[0]=1
- fwd_en  out  1  regWrite & ~memToReg (forwardable to EX)
- stall_cnt  out  CNT_W  stalled cycles, saturating

Behaviour:
- Reset (rst=0, async): valid=0, all data/control registers 0, halt=0, misalign=0, stall_cnt=0, FSM=RUN.
- Latency: 1 cycle. Inputs sampled at posedge appear on outputs after that edge.
- Load rule, in priority order:
  - stall=1: hold all registers; flush ignored (upstream must re-present).
  - Else flush=1 or FSM≠RUN: load bubble (valid=0, controls 0; data fields don't-care, load 0).
  - Else: load EX fields, valid<=ex_valid.
- Output gating: memWrite, MemRead, regWrite and fwd_en are all forced 0 when valid=0. Data outputs are not gated.
- misalign is combinational on registered state: valid & (memRead|memWrite) & aluRes[0].
  - When set, memWrite=MemRead=0, so memory is untouched.
  - regWrite is still passed through; the load then writes whatever the WB mux selects, and the trap path is owned elsewhere.
- Halt FSM:
  - RUN -> HALT_PULSE when an instruction with ex_halt=1 and ex_valid=1 is loaded (not on stall, not on flush).
  - HALT_PULSE: halt=1 for exactly one cycle. If stall=1, stay in HALT_PULSE with halt held until stall drops, then go to HALTED.
  - HALTED: halt=0 and only bubbles are loaded. Leaves only on reset.
  - A halt instruction carries no memory or register effect (memWrite/MemRead/regWrite forced 0 for it).
- stall_cnt: increments each cycle with stall=1, saturates at all-ones, cleared only by reset.
- Reset mid-stall or mid-halt: immediate async clear to RUN with bubble.
- A bubble cannot generate misalign, memory ops or halt.

Decomposition:
- Shared package: DATA_W/REG_W defaults, FSM state encoding (RUN=2'd0, HALT_PULSE=2'd1, HALTED=2'd2).
- One natural sub-module: sat_counter (width-parameterised, enable, async active-low clear), instantiated for stall_cnt.
- The rest is one register block plus the FSM.

Test Plan:
- Reset then load store: ex_valid=1, ex_memWrite=1, ex_aluRes=16'h0040, ex_writeData=16'hBEEF -> next cycle memWrite=1, aluRes=0040, writedata=BEEF, valid=1, misalign=0.
- Stall hold: load a load op to 0x0010, then stall=1 for 3 cycles with EX inputs changing -> outputs constant at 0x0010 for 3 cycles, stall_cnt=3; stall+flush together -> still held.
- Flush: flush=1 with ex_valid=1 load -> next cycle valid=0, MemRead=0, regWrite=0.
- Misalign: ex_memRead=1, ex_aluRes=16'h0021 -> misalign=1, MemRead=0, regWrite passes through.
- Halt: halt instruction loaded with stall=1 held for 2 cycles after load -> halt=1 for 3 cycles then 0; later ex_valid=1 stores -> memWrite stays 0 until reset.
- Async reset asserted mid-cycle while valid store present -> memWrite drops immediately without a clock edge; stall_cnt=0; saturation check: stall held 2^CNT_W+5 cycles -> stall_cnt=16'hFFFF.
